conv2d_stream: RTL and testbench
================================

Name: conv2d_stream

Overview:
- Parametrised streaming successor to the fixed 8x8-in / 7x7-out convolution block.
- Accepts a raster-order pixel stream of an IMG_H x IMG_W signed image and applies a run-time-loaded K x K signed kernel ("valid" convolution, stride 1).
- Emits (IMG_H-K+1) x (IMG_W-K+1) saturated results with ready/valid backpressure.
- Sits between the frame source and the output buffer of the convolution processor.

Parameters:
- IMG_W, 8, image width in pixels (>= K)
- IMG_H, 8, image height in pixels (>= K)
- K, 2, kernel side (1..8)
- DW, 8, signed pixel and weight width
- OUT_W, 16, signed output width; the result saturates to this width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_st  in  1  frame start pulse
- reuse_w  in  1  sampled with in_st; 1 = skip weight load and reuse the stored kernel
- w_valid  in  1  weight strobe
- w_data  in  DW  signed weight, raster order (row 0 col 0 first)
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel ready
- pix_data  in  DW  signed pixel
- dout_valid  out  1  result valid
- dout_ready  in  1  result ready
- dout  out  OUT_W  signed result
- out_st  out  1  one-cycle pulse: frame complete
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. On reset, all outputs are 0, the state is IDLE, counters and stored weights are 0, and the weights-loaded flag is cleared. Line-buffer RAM is not cleared.
- States:
  - IDLE: on in_st, go to LOAD_W. If reuse_w=1 and the weights-loaded flag is set, go to RUN instead. in_st is ignored in all other states.
  - LOAD_W: each w_valid stores one weight. The K*K-th weight sets the weights-loaded flag and moves to RUN. pix_ready=0.
  - RUN: pix_ready = !dout_valid || dout_ready. A pixel is accepted when pix_valid && pix_ready.
    - Column counter wraps IMG_W-1 -> 0 and increments the row counter.
    - Acceptance of pixel (IMG_H-1, IMG_W-1) moves to DRAIN.
  - DRAIN: pix_ready=0. When dout_valid && dout_ready, assert out_st for exactly 1 cycle and go to IDLE.
- Window: K-1 line buffers of IMG_W entries plus a K x K shift window. The accepted pixel at (r,c) completes the window whose bottom-right corner is (r,c).
- Output generation: output only when r >= K-1 and c >= K-1. dout and dout_valid are registered, with latency 1 cycle after acceptance. Positions without output do not touch dout_valid.
- Output handshake: dout and dout_valid hold until dout_ready. When dout_valid && dout_ready and no new result is generated in the same cycle, dout_valid deasserts. A simultaneous accept and new result loads the new value with no bubble.
- Arithmetic:
  - Products are 2*DW signed.
  - Accumulator ACC_W = 2*DW + clog2(K*K) bits, full precision with no intermediate rounding.
  - The final value saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Ordering: outputs appear in raster order of window position. The count is exactly (IMG_H-K+1)*(IMG_W-K+1) per frame.
- K=1: every pixel produces an output; no line buffers are instantiated.
- Reset mid-frame: aborts immediately; any pending dout is dropped. The next frame requires a full weight load.
- Pixels offered outside RUN are not accepted. w_valid outside LOAD_W is ignored.

Optional Feature:
- Macro: CONV2D_RELU_EN.
- Defined: after saturation, negative results are replaced by 0 (ReLU); latency is unchanged.
- Undefined: signed saturated result passes through unchanged.

Decomposition:
- Shared package conv_pkg:
  - state enum (IDLE, LOAD_W, RUN, DRAIN)
  - acc_width(DW,K) constant function
  - sat_to_out signed saturation function
  - clog2 helper
- One natural sub-module, conv_line_buffer: K-1 circular line stores and the K x K window register, advanced on pixel accept, presenting the window as a flat array.

Test Plan:
- Default params, K=2, all weights 1, all pixels 1, dout_ready=1 -> 49 outputs each 4, then out_st pulse 1 cycle after the 49th handshake.
- K=3, weights 127, pixels 127 -> every output saturates to 32767. With weights -128, pixels 127 -> -32768. With CONV2D_RELU_EN, the negative case gives 0.
- K=3, identity kernel (centre weight 1, others 0), pixel value = 8r+c -> output (i,j) = 8(i+1)+(j+1), 36 outputs in raster order.
- Backpressure: dout_ready low for 5 cycles mid-frame -> pix_ready=0 while dout_valid is held, dout stable, no lost or duplicated result, total count still 49.
- Second frame with reuse_w=1 -> LOAD_W skipped, same results. in_st asserted during RUN -> ignored; busy stays 1.
- Reset asserted mid-RUN -> next cycle dout_valid=0, busy=0, out_st=0. A reuse_w=1 start after reset goes to LOAD_W.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: state encoding and arithmetic helpers shared by conv2d_stream
// and its line-buffer sub-module.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Full-precision accumulator width for a K*K sum of DW x DW products.
    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + clog2(k * k);
    endfunction

    // Clamp a sign-extended value into the signed range of an out_w-bit result.
    function automatic logic signed [63:0] sat_to_out(input logic signed [63:0] v,
                                                      input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: K-1 column-indexed line stores plus the K x (K-1) window
// history. o_win is the full K x K window completed by the pixel currently on
// i_pix (row-major, row 0 = oldest row, column 0 = leftmost), so the caller
// can register a result in the same cycle the pixel is accepted.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int K     = 2,
    parameter int DW    = 8,
    parameter int CW    = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1
) (
    input  logic              clk,
    input  logic              i_adv,
    input  logic [CW-1:0]     i_col,
    input  logic [DW-1:0]     i_pix,
    output logic [K*K*DW-1:0] o_win
);

    generate
        if (K > 1) begin : g_win
            logic [DW-1:0] r_lb  [K-1][IMG_W];
            logic [DW-1:0] r_win [K][K-1];
            logic [DW-1:0] w_col [K];

            // Column entering the window: K-1 stored rows above plus the live pixel.
            always_comb begin
                for (int j = 0; j < K - 1; j++) w_col[j] = r_lb[j][i_col];
                w_col[K-1] = i_pix;
            end

            // On accept, each line store ages by one row at this column and the window slides left.
            always_ff @(posedge clk) begin
                if (i_adv) begin
                    for (int j = 0; j < K - 2; j++) r_lb[j][i_col] <= r_lb[j+1][i_col];
                    r_lb[K-2][i_col] <= i_pix;
                    for (int rr = 0; rr < K; rr++) begin
                        for (int cc = 0; cc < K - 2; cc++) r_win[rr][cc] <= r_win[rr][cc+1];
                        r_win[rr][K-2] <= w_col[rr];
                    end
                end
            end

            // Flatten the stored columns with the incoming column on the right.
            always_comb begin
                o_win = '0;
                for (int rr = 0; rr < K; rr++) begin
                    for (int cc = 0; cc < K - 1; cc++)
                        o_win[(rr*K+cc)*DW +: DW] = r_win[rr][cc];
                    o_win[(rr*K+K-1)*DW +: DW] = w_col[rr];
                end
            end
        end else begin : g_pass
            assign o_win = i_pix;
        end
    endgenerate

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming K x K "valid" convolution (stride 1) over an
// IMG_H x IMG_W signed raster image, run-time loaded kernel, saturated
// OUT_W-bit results with ready/valid backpressure.
// Build option: define CONV2D_RELU_EN to replace negative results with 0.
//
// state  | meaning
// IDLE   | waiting for in_st
// LOAD_W | storing K*K weights, one per w_valid
// RUN    | accepting pixels, producing results
// DRAIN  | last pixel taken, waiting for the final result handshake
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 2,
    parameter int DW    = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_st,
    input  logic                    reuse_w,
    input  logic                    w_valid,
    input  logic [DW-1:0]           w_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [DW-1:0]           pix_data,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic signed [OUT_W-1:0] dout,
    output logic                    out_st,
    output logic                    busy
);

    localparam int KK    = K * K;
    localparam int ACC_W = acc_width(DW, K);
    localparam int CW    = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1;
    localparam int RW    = (clog2(IMG_H) > 0) ? clog2(IMG_H) : 1;
    localparam int IW    = (clog2(KK) > 0) ? clog2(KK) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [IW-1:0] W_LAST    = IW'(KK - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_wloaded;
    logic [IW-1:0]           r_widx;
    logic signed [DW-1:0]    r_w [KK];
    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic signed [OUT_W-1:0] r_dout;
    logic                    r_dout_valid;
    logic                    r_out_st;

    logic                    w_pix_ready;
    logic                    w_pix_acc;
    logic                    w_w_acc;
    logic                    w_w_last;
    logic                    w_last_pix;
    logic                    w_out_pos;
    logic                    w_gen;
    logic                    w_dout_hs;
    logic                    w_out_st_nxt;
    logic                    w_fresh_load;
    logic [K*K*DW-1:0]       w_win;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [OUT_W-1:0] w_sat;
    logic signed [OUT_W-1:0] w_res;

    assign w_dout_hs    = r_dout_valid && dout_ready;
    assign w_pix_acc    = pix_valid && w_pix_ready;
    assign w_w_acc      = (r_state == LOAD_W) && w_valid;
    assign w_w_last     = w_w_acc && (r_widx == W_LAST);
    assign w_last_pix   = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_out_pos    = (r_row >= ROW_FIRST) && (r_col >= COL_FIRST);
    assign w_gen        = w_pix_acc && w_out_pos;
    assign w_fresh_load = (r_state == IDLE) && in_st && !(reuse_w && r_wloaded);

    // Next state, pixel ready and frame-complete strobe.
    always_comb begin
        w_state_nxt  = r_state;
        w_pix_ready  = 1'b0;
        w_out_st_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_st) w_state_nxt = (reuse_w && r_wloaded) ? RUN : LOAD_W;
            end
            LOAD_W: begin
                if (w_w_last) w_state_nxt = RUN;
            end
            RUN: begin
                w_pix_ready = !r_dout_valid || dout_ready;
                if (w_pix_ready && pix_valid && w_last_pix) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_dout_hs) begin
                    w_out_st_nxt = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Kernel store; a fresh load invalidates the stored kernel until it completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wloaded <= 1'b0;
            r_widx    <= '0;
            for (int i = 0; i < KK; i++) r_w[i] <= '0;
        end else if (w_fresh_load) begin
            r_wloaded <= 1'b0;
            r_widx    <= '0;
        end else if (w_w_acc) begin
            r_w[r_widx] <= w_data;
            if (w_w_last) begin
                r_widx    <= '0;
                r_wloaded <= 1'b1;
            end else begin
                r_widx <= r_widx + 1'b1;
            end
        end
    end

    // Raster position of the next pixel; returns to (0,0) after the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_pix_acc) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    conv_line_buffer #(
        .IMG_W (IMG_W),
        .K     (K),
        .DW    (DW),
        .CW    (CW)
    ) u_line_buffer (
        .clk   (clk),
        .i_adv (w_pix_acc),
        .i_col (r_col),
        .i_pix (pix_data),
        .o_win (w_win)
    );

    // Full-precision multiply-accumulate over the window completed by this pixel.
    always_comb begin
        w_prod = '0;
        w_acc  = '0;
        for (int i = 0; i < KK; i++) begin
            w_prod = (2*DW)'(r_w[i]) * (2*DW)'($signed(w_win[i*DW +: DW]));
            w_acc  = w_acc + ACC_W'(w_prod);
        end
    end

    assign w_sat = OUT_W'(sat_to_out(64'(w_acc), OUT_W));

`ifdef CONV2D_RELU_EN
    assign w_res = w_sat[OUT_W-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    // Result register: load on a new result, otherwise hold until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_gen) begin
            r_dout       <= w_res;
            r_dout_valid <= 1'b1;
        end else if (w_dout_hs) begin
            r_dout_valid <= 1'b0;
        end
    end

    // One-cycle frame-complete pulse following the final result handshake.
    always_ff @(posedge clk) begin
        if (reset) r_out_st <= 1'b0;
        else       r_out_st <= w_out_st_nxt;
    end

    assign pix_ready  = w_pix_ready;
    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign out_st     = r_out_st;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: a K=2 and a K=3 instance share the input buses;
// only the selected instance is started, the other stays idle.
module tb_conv2d_stream;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_st2 = 1'b0, in_st3 = 1'b0;
    logic reuse_w = 1'b0;
    logic w_valid = 1'b0;
    logic [7:0] w_data = '0;
    logic pix_valid = 1'b0;
    logic [7:0] pix_data = '0;
    logic dout_ready = 1'b1;

    logic pr2, dv2, os2, b2, pr3, dv3, os3, b3;
    logic signed [15:0] d2, d3;

    logic sel3 = 1'b0;
    logic pr, dv, os, busy;
    logic signed [15:0] dout;

    int vectors = 0;
    int miscompares = 0;
    bit loaded2 = 0, loaded3 = 0;
    int img [8][8];
    int wt [9];
    int exp_q [$];

    always #5 clk = ~clk;

    assign pr   = sel3 ? pr3 : pr2;
    assign dv   = sel3 ? dv3 : dv2;
    assign os   = sel3 ? os3 : os2;
    assign busy = sel3 ? b3  : b2;
    assign dout = sel3 ? d3  : d2;

    conv2d_stream #(.IMG_W(8), .IMG_H(8), .K(2), .DW(8), .OUT_W(16)) dut2 (
        .clk(clk), .reset(reset), .in_st(in_st2), .reuse_w(reuse_w),
        .w_valid(w_valid), .w_data(w_data), .pix_valid(pix_valid), .pix_ready(pr2),
        .pix_data(pix_data), .dout_valid(dv2), .dout_ready(dout_ready), .dout(d2),
        .out_st(os2), .busy(b2));

    conv2d_stream #(.IMG_W(8), .IMG_H(8), .K(3), .DW(8), .OUT_W(16)) dut3 (
        .clk(clk), .reset(reset), .in_st(in_st3), .reuse_w(reuse_w),
        .w_valid(w_valid), .w_data(w_data), .pix_valid(pix_valid), .pix_ready(pr3),
        .pix_data(pix_data), .dout_valid(dv3), .dout_ready(dout_ready), .dout(d3),
        .out_st(os3), .busy(b3));

    // Reference: direct 2-D sum for the window with top-left corner (i,j).
    function automatic int model_out(input int k, input int i, input int j);
        longint acc;
        acc = 0;
        for (int a = 0; a < k; a++)
            for (int b = 0; b < k; b++)
                acc += longint'(wt[a*k+b]) * longint'(img[i+a][j+b]);
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`ifdef CONV2D_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return int'(acc);
    endfunction

    task automatic run_frame(input string name, input int k, input bit reuse,
                             input int stall_at, input bit poke);
        int total, nout, p, cyc, stall_left, wi, r, c, e;
        bit os_due, done, exp_load, held_v;
        logic signed [15:0] held;
        total = (9 - k) * (9 - k);
        exp_load = !(reuse && (sel3 ? loaded3 : loaded2));
        exp_q.delete();
        dout_ready = 1'b1;
        @(negedge clk);
        if (sel3) in_st3 = 1'b1; else in_st2 = 1'b1;
        reuse_w = reuse;
        @(negedge clk);
        in_st2 = 1'b0; in_st3 = 1'b0; reuse_w = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s start_busy: got %b expected 1", name, busy);
        end
        if (exp_load) begin
            wi = 0;
            while (wi < k * k) begin
                vectors++;
                if (pr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s load_pix_ready: got %b expected 0", name, pr);
                end
                if ($urandom_range(0, 3) == 0) w_valid = 1'b0;
                else begin
                    w_valid = 1'b1;
                    w_data = 8'(wt[wi]);
                    wi++;
                end
                @(negedge clk);
            end
            w_valid = 1'b0;
            if (sel3) loaded3 = 1; else loaded2 = 1;
        end else begin
            vectors++;
            if (pr !== 1'b1) begin
                miscompares++;
                $display("FAIL %s reuse_skip_load: pix_ready got %b expected 1", name, pr);
            end
        end
        p = 0; nout = 0; cyc = 0; stall_left = 0;
        os_due = 0; done = 0; held_v = 0; held = '0;
        while (!done && cyc < 3000) begin
            if (cyc == stall_at) stall_left = 5;
            dout_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (p < 64) begin
                pix_valid = ($urandom_range(0, 4) != 0);
                pix_data = 8'(img[p/8][p%8]);
            end else begin
                pix_valid = 1'b0;
            end
            if (sel3) in_st3 = (poke && cyc == 10); else in_st2 = (poke && cyc == 10);
            #1;
            vectors++;
            if (os !== os_due) begin
                miscompares++;
                $display("FAIL %s out_st: got %b expected %b (outputs %0d)", name, os, os_due, nout);
            end
            if (os_due) begin
                done = 1;
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s end_busy: got %b expected 0", name, busy);
                end
            end
            os_due = 0;
            if (poke && cyc == 11) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s in_st_in_run busy: got %b expected 1", name, busy);
                end
            end
            if (held_v) begin
                vectors++;
                if (dv !== 1'b1 || dout !== held) begin
                    miscompares++;
                    $display("FAIL %s hold: got valid=%b dout=%0d expected valid=1 dout=%0d", name, dv, dout, held);
                end
            end
            held_v = 0;
            if (dv && !dout_ready) begin
                vectors++;
                if (pr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s stall_pix_ready: got %b expected 0", name, pr);
                end
                held_v = 1;
                held = dout;
            end
            if (dv && dout_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_output: got %0d expected none", name, dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== 16'(e)) begin
                        miscompares++;
                        $display("FAIL %s dout[%0d]: got %0d expected %0d", name, nout, dout, e);
                    end
                end
                nout++;
                if (nout == total) os_due = 1;
            end
            if (pix_valid && pr) begin
                r = p / 8; c = p % 8;
                if (r >= k - 1 && c >= k - 1) exp_q.push_back(model_out(k, r - k + 1, c - k + 1));
                p++;
            end
            cyc++;
            @(negedge clk);
        end
        pix_valid = 1'b0; dout_ready = 1'b1; in_st2 = 1'b0; in_st3 = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s timeout: got %0d outputs expected %0d then out_st", name, nout, total);
        end
        vectors++;
        if (nout != total || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s count: got %0d outputs (%0d pending) expected %0d", name, nout, exp_q.size(), total);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({pr2, dv2, os2, b2, pr3, dv3, os3, b3} !== 8'b0 || d2 !== 16'sd0 || d3 !== 16'sd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ctl=%b d2=%0d d3=%0d expected all 0",
                     {pr2, dv2, os2, b2, pr3, dv3, os3, b3}, d2, d3);
        end
        reset = 1'b0;
        loaded2 = 0; loaded3 = 0;
    endtask

    task automatic test_idle_ignore();
        pix_valid = 1'b1; w_valid = 1'b1; w_data = 8'd5; pix_data = 8'd7;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if ({pr2, dv2, b2, pr3, dv3, b3} !== 6'b0) begin
                miscompares++;
                $display("FAIL idle_ignore: got ready/valid/busy=%b expected 0", {pr2, dv2, b2, pr3, dv3, b3});
            end
        end
        pix_valid = 1'b0; w_valid = 1'b0;
    endtask

    task automatic test_ones_k2();
        sel3 = 1'b0;
        for (int i = 0; i < 4; i++) wt[i] = 1;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 1;
        run_frame("ones_k2", 2, 1'b0, -1, 1'b0);
    endtask

    task automatic test_identity_k3();
        sel3 = 1'b1;
        for (int i = 0; i < 9; i++) wt[i] = (i == 4) ? 1 : 0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 8 * r + c;
        run_frame("identity_k3", 3, 1'b0, -1, 1'b0);
    endtask

    task automatic test_saturate_k3();
        sel3 = 1'b1;
        for (int i = 0; i < 9; i++) wt[i] = 127;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 127;
        run_frame("sat_pos_k3", 3, 1'b0, -1, 1'b0);
        for (int i = 0; i < 9; i++) wt[i] = -128;
        run_frame("sat_neg_k3", 3, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure_k2();
        sel3 = 1'b0;
        for (int i = 0; i < 4; i++) wt[i] = int'($urandom_range(0, 255)) - 128;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = int'($urandom_range(0, 255)) - 128;
        run_frame("backpressure_k2", 2, 1'b0, 30, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel3 = 1'b0;
        run_frame("reuse_k2", 2, 1'b1, 20, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        sel3 = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        in_st2 = 1'b1; reuse_w = 1'b1;
        @(negedge clk);
        in_st2 = 1'b0; reuse_w = 1'b0;
        pix_valid = 1'b1;
        repeat (20) begin
            pix_data = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        vectors++;
        if (dv2 !== 1'b1 || b2 !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_run: got valid=%b busy=%b expected 1 1", dv2, b2);
        end
        reset = 1'b1; pix_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({dv2, b2, os2, pr2} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run: got valid/busy/out_st/ready=%b expected 0000", {dv2, b2, os2, pr2});
        end
        @(negedge clk);
        reset = 1'b0;
        loaded2 = 0; loaded3 = 0;
        for (int i = 0; i < 4; i++) wt[i] = int'($urandom_range(0, 15)) - 8;
        run_frame("after_reset_k2", 2, 1'b1, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_ones_k2();
        test_identity_k3();
        test_saturate_k3();
        test_backpressure_k2();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
